// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Single-clock FIFO with parametrised width and depth. Provides an occupancy
//   count, programmable almost-full and almost-empty thresholds, a registered
//   read-data valid strobe, overflow and underflow pulses, and sticky error status.
//
// Ports
//   clock        rising-edge clock for all logic
//   reset        synchronous, active-high
//   read, write  read and write requests
//   fifo_in      write data
//   clear_err    clears err_status (a new error in the same cycle wins)
//   fifo_out     registered read data; holds its value when no read is accepted
//   out_valid    one-cycle strobe: fifo_out holds a newly read word
//   fifo_count   occupancy, 0..DEPTH
//   fifo_empty, fifo_full, fifo_half, almost_empty, almost_full
//                flags decoded from the count register only
//   overflow     one-cycle pulse: the previous write was rejected
//   underflow    one-cycle pulse: the previous read was rejected
//   err_status   sticky {overflow_seen, underflow_seen}
module sync_fifo_param #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [WIDTH-1:0]  fifo_in,
    input  logic              clear_err,
    output logic [WIDTH-1:0]  fifo_out,
    output logic              out_valid,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              fifo_half,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow,
    output logic [1:0]        err_status
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] HALF_C  = (ADDR_W+1)'(DEPTH / 2);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [WIDTH-1:0]  ram [DEPTH];

    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic [1:0]        err_q, err_d;

    logic full_w, empty_w, wr_ok, rd_ok;

    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    // A write into a full FIFO is accepted only when a read frees a slot in the
    // same cycle. There is no bypass: an empty FIFO rejects a read even when a
    // write arrives at the same time.
    assign wr_ok = write & (~full_w | read);
    assign rd_ok = read & ~empty_w;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        ovf_d    = write & ~wr_ok;
        udf_d    = read & ~rd_ok;
        err_d    = err_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            dout_d   = ram[rd_ptr_q];
            valid_d  = 1'b1;
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + ONE_C;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - ONE_C;
        end

        // Clear first so that an error in the same cycle sets the bit again.
        if (clear_err) begin
            err_d = 2'b00;
        end
        err_d = err_d | {ovf_d, udf_d};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            err_q    <= 2'b00;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            err_q    <= err_d;
        end
    end

    // The storage array is not reset. A write that is issued in the same cycle
    // as reset is dropped, because the pointers return to zero anyway.
    always_ff @(posedge clock) begin
        if (!reset && wr_ok) begin
            ram[wr_ptr_q] <= fifo_in;
        end
    end

    assign fifo_out     = dout_q;
    assign out_valid    = valid_q;
    assign fifo_count   = count_q;
    assign fifo_empty   = empty_w;
    assign fifo_full    = full_w;
    assign fifo_half    = (count_q >= HALF_C);
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign err_status   = err_q;

endmodule
